// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: takes a WIDTH-bit word over valid/ready and
// shifts it out one bit per clock with per-bit valid and a last-bit flag.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             data,
  output logic             data_valid,
  output logic             data_last,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PEN_BIT  = CW'(WIDTH - 2);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam bit            NO_GAP   = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic             last_cycle;
  logic             accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // NOTE: continuous assigns from registered state cannot infer latches and
  // keep din_ready free of any combinational path from din_valid.
  assign last_cycle = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign din_ready  = !rst && ((state == IDLE) || (NO_GAP && last_cycle));
  assign accept     = din_valid && din_ready;
  assign busy       = (state != IDLE);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      data       <= 1'b0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state      <= SHIFT;
            bit_cnt    <= '0;
            data       <= first_bit(din);
            shreg      <= shift_out(din);
            data_valid <= 1'b1;
            data_last  <= 1'b0;
          end
        end
        SHIFT: begin
          if (!last_cycle) begin
            bit_cnt   <= bit_cnt + 1'b1;
            data      <= first_bit(shreg);
            shreg     <= shift_out(shreg);
            data_last <= (bit_cnt == PEN_BIT);
          end else if (accept) begin
            // Back-to-back word: counter wraps, no bubble on data_valid.
            bit_cnt    <= '0;
            data       <= first_bit(din);
            shreg      <= shift_out(din);
            data_valid <= 1'b1;
            data_last  <= 1'b0;
          end else begin
            state      <= NO_GAP ? IDLE : GAP;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            data       <= 1'b0;
            data_valid <= 1'b0;
            data_last  <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first/no gap, LSB-first/gap 2)
// checked every cycle against a cycle-indexed transaction model plus SIPO scoreboard.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic [1:0]   ready, dat, dval, dlast, busy;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(ready[0]), .data(dat[0]), .data_valid(dval[0]),
    .data_last(dlast[0]), .busy(busy[0])
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(ready[1]), .data(dat[1]), .data_valid(dval[1]),
    .data_last(dlast[1]), .busy(busy[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (cycle-indexed word windows) ----------------
  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction
  function automatic bit msb_of(input int i);
    return (i == 0);
  endfunction
  function automatic string nm(input int i);
    return (i == 0) ? "a" : "b";
  endfunction

  int           cyc = 0;
  int           next_ready[2];
  int           ws[2];
  logic [W-1:0] wv[2];
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           acc_a = 0;
  bit           chk_en = 1'b0;

  function automatic bit m_ready(input int i);
    return !rst && (cyc >= next_ready[i]);
  endfunction
  function automatic bit m_valid(input int i);
    return (cyc >= ws[i]) && (cyc < ws[i] + W);
  endfunction
  function automatic bit m_bit(input int i);
    int k;
    k = cyc - ws[i];
    return msb_of(i) ? wv[i][W-1-k] : wv[i][k];
  endfunction
  function automatic bit m_last(input int i);
    return m_valid(i) && (cyc - ws[i] == W - 1);
  endfunction
  function automatic bit m_busy(input int i);
    return m_valid(i) || (cyc < next_ready[i]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ws[i]         = -100;
        next_ready[i] = cyc + 1;
        if (i == 0) q0.delete(); else q1.delete();
      end else if (din_valid && m_ready(i)) begin
        ws[i]         = cyc + 1;
        wv[i]         = din;
        next_ready[i] = cyc + W + ((gap_of(i) > 0) ? gap_of(i) + 1 : 0);
        if (i == 0) begin q0.push_back(din); acc_a++; end
        else        q1.push_back(din);
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare + SIPO scoreboard ----------------
  logic [W-1:0] sipo[2];
  logic [W-1:0] want;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("%s.din_ready", nm(i)), 32'(ready[i]), 32'(m_ready(i)));
        check($sformatf("%s.data_valid", nm(i)), 32'(dval[i]), 32'(m_valid(i)));
        check($sformatf("%s.data", nm(i)), 32'(dat[i]), 32'(m_valid(i) ? m_bit(i) : 1'b0));
        check($sformatf("%s.data_last", nm(i)), 32'(dlast[i]), 32'(m_last(i)));
        check($sformatf("%s.busy", nm(i)), 32'(busy[i]), 32'(m_busy(i)));
        if (dval[i]) begin
          sipo[i] = msb_of(i) ? {sipo[i][W-2:0], dat[i]} : {dat[i], sipo[i][W-1:1]};
          if (dlast[i]) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
              check($sformatf("%s.sipo_unexpected", nm(i)), 32'(1), 32'(0));
            end else begin
              want = (i == 0) ? q0.pop_front() : q1.pop_front();
              check($sformatf("%s.sipo_word", nm(i)), 32'(sipo[i]), 32'(want));
            end
          end
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    din_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [W-1:0]   cap_a, cap_b, last_a, rdy_a;
    logic [2*W-1:0] v16, l16, b16;
    int t1, t2, gl, start;

    // Reset
    rst = 1'b1;
    @(negedge clk);
    check("rst.ready_a", 32'(ready[0]), 32'(0));
    check("rst.ready_b", 32'(ready[1]), 32'(0));
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // 1: 8'hA5 on both instances
    din = 8'hA5; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      cap_a[W-1-k]  = dat[0];
      last_a[W-1-k] = dlast[0];
      rdy_a[W-1-k]  = ready[0];
      cap_b[k]      = dat[1];
      tick();
    end
    check("t1.bits_a", 32'(cap_a), 32'h0000_00A5);
    check("t1.last_a", 32'(last_a), 32'h0000_0001);
    check("t1.ready_a", 32'(rdy_a), 32'h0000_0001);
    check("t1.bits_b", 32'(cap_b), 32'h0000_00A5);
    check("t1.sipo_a", 32'(sipo[0]), 32'h0000_00A5);
    settle(6);

    // 4: LSB-first 8'h01, din changed mid-word
    din = 8'h01; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din = 8'hFF;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      cap_b[W-1-k] = dat[1];
      cap_a[W-1-k] = dat[0];
      tick();
    end
    check("t4.seq_b", 32'(cap_b), 32'h0000_0080);
    check("t4.seq_a", 32'(cap_a), 32'h0000_0001);
    settle(6);

    // 2: back-to-back 3C, C3 on the no-gap instance
    din = 8'h3C; din_valid = 1'b1;
    tick();
    din = 8'hC3;
    for (int k = 0; k < 2*W; k++) begin
      @(negedge clk);
      v16[2*W-1-k] = dval[0];
      l16[2*W-1-k] = dlast[0];
      b16[2*W-1-k] = dat[0];
      tick();
      if (k == W - 1) din_valid = 1'b0;
    end
    check("t2.valid", 32'(v16), 32'h0000_FFFF);
    check("t2.last", 32'(l16), 32'h0000_0101);
    check("t2.bits", 32'(b16), 32'h0000_3CC3);
    check("t2.sipo_a", 32'(sipo[0]), 32'h0000_00C3);
    settle(6);

    // 3: gap instance with din_valid held high
    din = 8'h5A; din_valid = 1'b1;
    t1 = -1; t2 = -1; gl = 0;
    for (int k = 0; k < 40 && t2 < 0; k++) begin
      @(negedge clk);
      if (t1 >= 0 && !dval[1] && !ready[1]) gl++;
      if (ready[1]) begin
        if (t1 < 0) t1 = k;
        else        t2 = k;
      end
      tick();
      if (t1 == k) din = 8'h96;
    end
    if (t2 < 0) begin
      check("t3.timeout", 32'(0), 32'(1));
    end else begin
      check("t3.spacing", 32'(t2 - t1), 32'(11));
      check("t3.gap_idle", 32'(gl), 32'(2));
    end
    settle(14);

    // 5: reset after 3 bits of F0, with a coincident transfer attempt
    din = 8'hF0; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tick();
    end
    rst = 1'b1; din = 8'hEE; din_valid = 1'b1;
    @(negedge clk);
    check("t5.ready_in_rst_a", 32'(ready[0]), 32'(0));
    check("t5.ready_in_rst_b", 32'(ready[1]), 32'(0));
    tick();
    rst = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    check("t5.valid_after", 32'(dval[0]), 32'(0));
    check("t5.busy_after", 32'(busy[0]), 32'(0));
    check("t5.ready_after", 32'(ready[0]), 32'(1));
    tick();
    din = 8'h81; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      cap_a[W-1-k] = dat[0];
      tick();
    end
    check("t5.bits_a", 32'(cap_a), 32'h0000_0081);
    settle(12);

    // 6: random traffic, at least 100 words through instance a
    start = acc_a;
    for (int k = 0; k < 3000 && (acc_a - start) < 100; k++) begin
      din       = W'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    din_valid = 1'b0;
    check("t6.word_count", 32'((acc_a - start) >= 100), 32'(1));
    settle(16);
    check("t6.drained", 32'(q0.size() + q1.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
